// File: rtl/mem_access_ctrl_if.sv
// Bundles the EX/MEM-side request signals and the SRAM port of mem_access_ctrl.
// The master modport drives requests and SRAM responses; the slave modport belongs to the controller.
interface mem_access_ctrl_if #(
  parameter int unsigned ADDR_W = 16
);
  logic              MEM_R_EN;
  logic              MEM_W_EN;
  logic [31:0]       ALU_Res;
  logic [31:0]       Val_Rm;
  logic [31:0]       SRAM_RDATA;
  logic              SRAM_ACK;
  logic              SRAM_REQ;
  logic              SRAM_WE;
  logic [ADDR_W-1:0] SRAM_ADDR;
  logic [31:0]       SRAM_WDATA;
  logic [31:0]       Read_Data;
  logic              Ready;
  logic              Freeze;

  modport master (
    output MEM_R_EN, MEM_W_EN, ALU_Res, Val_Rm, SRAM_RDATA, SRAM_ACK,
    input  SRAM_REQ, SRAM_WE, SRAM_ADDR, SRAM_WDATA, Read_Data, Ready, Freeze
  );

  modport slave (
    input  MEM_R_EN, MEM_W_EN, ALU_Res, Val_Rm, SRAM_RDATA, SRAM_ACK,
    output SRAM_REQ, SRAM_WE, SRAM_ADDR, SRAM_WDATA, Read_Data, Ready, Freeze
  );
endinterface

// File: rtl/mem_access_ctrl.sv
// Data-memory access sequencer between EX/MEM and MEM/WB: latches one request, drives the SRAM, freezes the pipeline.
// Define SRAM_ACK_EN to end accesses on SRAM_ACK instead of the fixed WAIT_CYCLES counter.
module mem_access_ctrl #(
  parameter int unsigned WAIT_CYCLES = 5,
  parameter int unsigned BASE_ADDR   = 1024,
  parameter int unsigned ADDR_W      = 16
) (
  input logic              CLK,
  input logic              RST,
  mem_access_ctrl_if.slave bus
);

  typedef enum logic [1:0] {
    IDLE,
    ACCESS,
    DONE
  } state_t;

  state_t            state;
  logic              we_q;
  logic [ADDR_W-1:0] addr_q;
  logic [31:0]       wdata_q;
  logic [31:0]       rdata_q;
  logic              req_q;
  logic              ready_q;

  logic              mem_req;
  logic [31:0]       byte_off;
  logic              access_end;

  assign mem_req  = bus.MEM_R_EN | bus.MEM_W_EN;
  // Modular 32-bit subtraction: addresses below BASE_ADDR wrap silently.
  assign byte_off = bus.ALU_Res - BASE_ADDR;

`ifdef SRAM_ACK_EN
  assign access_end = bus.SRAM_ACK;
`else
  localparam int unsigned    CNT_W    = (WAIT_CYCLES > 1) ? $clog2(WAIT_CYCLES) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WAIT_CYCLES - 1);

  logic [CNT_W-1:0] cnt;

  assign access_end = (cnt == CNT_LAST);
`endif

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state   <= IDLE;
      we_q    <= 1'b0;
      addr_q  <= '0;
      wdata_q <= '0;
      rdata_q <= '0;
      req_q   <= 1'b0;
      ready_q <= 1'b0;
`ifndef SRAM_ACK_EN
      cnt     <= '0;
`endif
    end else begin
      ready_q <= 1'b0;
      case (state)
        IDLE: begin
          if (mem_req) begin
            state   <= ACCESS;
            req_q   <= 1'b1;
            // A simultaneous read and write request is carried out as a write.
            we_q    <= bus.MEM_W_EN;
            addr_q  <= ADDR_W'(byte_off >> 2);
            wdata_q <= bus.Val_Rm;
          end
        end
        ACCESS: begin
`ifndef SRAM_ACK_EN
          cnt <= cnt + 1'b1;
`endif
          if (access_end) begin
            state   <= DONE;
            req_q   <= 1'b0;
            ready_q <= 1'b1;
`ifndef SRAM_ACK_EN
            cnt     <= '0;
`endif
            if (!we_q) begin
              rdata_q <= bus.SRAM_RDATA;
            end
          end
        end
        DONE: begin
          state <= IDLE;
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

  // Freeze is combinational so the request cycle itself already holds the pipeline.
  assign bus.Freeze     = (state == ACCESS) || ((state == IDLE) && mem_req);
  assign bus.SRAM_REQ   = req_q;
  assign bus.SRAM_WE    = we_q;
  assign bus.SRAM_ADDR  = addr_q;
  assign bus.SRAM_WDATA = wdata_q;
  assign bus.Read_Data  = rdata_q;
  assign bus.Ready      = ready_q;

endmodule

// File: tb/tb_mem_access_ctrl.sv
// Self-checking bench for mem_access_ctrl: directed scenarios plus randomized traffic against a timeline model.
// Honours SRAM_ACK_EN when the design is built with it.
module tb_mem_access_ctrl;

  localparam int unsigned W    = 5;
  localparam int unsigned BASE = 1024;
  localparam int unsigned AW   = 16;

  logic CLK;
  logic RST;

  mem_access_ctrl_if #(.ADDR_W(AW)) bus ();

  mem_access_ctrl #(
    .WAIT_CYCLES(W),
    .BASE_ADDR  (BASE),
    .ADDR_W     (AW)
  ) dut (
    .CLK(CLK),
    .RST(RST),
    .bus(bus.slave)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  int errors = 0;
  int checks = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at t=%0t", name, act, exp, $time);
    end
  endtask

  // Timeline model: an accepted op owns cycles [start_k, done_k) as ACCESS and done_k as DONE.
  int unsigned cyc = 0;
  bit          busy = 1'b0;
  int unsigned done_k = 0;
  logic          m_we = 1'b0;
  logic [AW-1:0] m_addr = '0;
  logic [31:0]   m_wdata = '0;
  logic [31:0]   m_rd = '0;
  logic          in_acc, in_done, want;

  // Observation statistics used by the directed scenarios.
  int          freeze_cnt = 0;
  int          req_cycles = 0;
  int          ready_cnt  = 0;
  int unsigned ready_cyc [2];
  logic          seen_we = 1'b0;
  logic [AW-1:0] seen_addr = '0;
  logic [31:0]   seen_wdata = '0;

  task automatic clear_stats();
    freeze_cnt = 0;
    req_cycles = 0;
    ready_cnt  = 0;
    ready_cyc[0] = 0;
    ready_cyc[1] = 0;
  endtask

  always @(negedge CLK) begin
    cyc++;
    want = bus.MEM_R_EN | bus.MEM_W_EN;
    if (bus.Freeze === 1'b1) freeze_cnt++;
    if (bus.SRAM_REQ === 1'b1) begin
      req_cycles++;
      seen_we    = bus.SRAM_WE;
      seen_addr  = bus.SRAM_ADDR;
      seen_wdata = bus.SRAM_WDATA;
    end
    if (bus.Ready === 1'b1) begin
      if (ready_cnt < 2) ready_cyc[ready_cnt] = cyc;
      ready_cnt++;
    end

    if (RST) begin
      chk("rst_req",    bus.SRAM_REQ,   32'd0);
      chk("rst_ready",  bus.Ready,      32'd0);
      chk("rst_rdata",  bus.Read_Data,  32'd0);
      chk("rst_freeze", bus.Freeze,     want);
      chk("rst_we",     bus.SRAM_WE,    32'd0);
      chk("rst_addr",   bus.SRAM_ADDR,  32'd0);
      chk("rst_wdata",  bus.SRAM_WDATA, 32'd0);
      busy    = 1'b0;
      m_we    = 1'b0;
      m_addr  = '0;
      m_wdata = '0;
      m_rd    = '0;
    end else begin
      in_acc  = busy && (cyc < done_k);
      in_done = busy && (cyc == done_k);
      chk("req",    bus.SRAM_REQ,   in_acc);
      chk("ready",  bus.Ready,      in_done);
      chk("freeze", bus.Freeze,     in_acc || (!busy && want));
      chk("we",     bus.SRAM_WE,    m_we);
      chk("addr",   bus.SRAM_ADDR,  m_addr);
      chk("wdata",  bus.SRAM_WDATA, m_wdata);
      chk("rdata",  bus.Read_Data,  m_rd);
      if (in_acc) begin
`ifdef SRAM_ACK_EN
        if (bus.SRAM_ACK) done_k = cyc + 1;
`endif
        if ((cyc + 1 == done_k) && !m_we) m_rd = bus.SRAM_RDATA;
      end else if (in_done) begin
        busy = 1'b0;
      end else if (want) begin
        busy    = 1'b1;
`ifdef SRAM_ACK_EN
        done_k  = 32'hFFFF_FFFF;
`else
        done_k  = cyc + 1 + W;
`endif
        m_we    = bus.MEM_W_EN;
        m_addr  = AW'((bus.ALU_Res - BASE) / 4);
        m_wdata = bus.Val_Rm;
      end
    end
  end

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  task automatic wait_ready(input int n);
    for (int i = 0; i < 30 && ready_cnt < n; i++) tick();
  endtask

  initial begin
    RST            = 1'b1;
    bus.MEM_R_EN   = 1'b1;
    bus.MEM_W_EN   = 1'b0;
    bus.ALU_Res    = 32'd1032;
    bus.Val_Rm     = '0;
    bus.SRAM_RDATA = 32'hDEADBEEF;
    bus.SRAM_ACK   = 1'b0;

    // Reset with a pending load request
    @(negedge CLK);
    @(negedge CLK);
    chk("t1_req",    bus.SRAM_REQ,  32'd0);
    chk("t1_freeze", bus.Freeze,    32'd1);
    chk("t1_rdata",  bus.Read_Data, 32'd0);
    chk("t1_ready",  bus.Ready,     32'd0);
    tick();

`ifndef SRAM_ACK_EN
    // Load from 1032 -> word 2
    RST = 1'b0;
    clear_stats();
    tick();
    bus.MEM_R_EN = 1'b0;
    wait_ready(1);
    chk("t2_ready_cnt", ready_cnt,      32'd1);
    chk("t2_req_len",   req_cycles,     32'd5);
    chk("t2_freeze",    freeze_cnt,     32'd6);
    chk("t2_addr",      seen_addr,      32'd2);
    chk("t2_we",        seen_we,        32'd0);
    chk("t2_rdata",     bus.Read_Data,  32'hDEADBEEF);

    // Store to 1024 -> word 0
    clear_stats();
    bus.MEM_W_EN = 1'b1;
    bus.ALU_Res  = 32'd1024;
    bus.Val_Rm   = 32'h12345678;
    bus.SRAM_RDATA = 32'h0BAD0BAD;
    tick();
    bus.MEM_W_EN = 1'b0;
    wait_ready(1);
    chk("t3_we",      seen_we,       32'd1);
    chk("t3_addr",    seen_addr,     32'd0);
    chk("t3_wdata",   seen_wdata,    32'h12345678);
    chk("t3_req_len", req_cycles,    32'd5);
    chk("t3_rdata",   bus.Read_Data, 32'hDEADBEEF);

    // Back-to-back load then R=W=1 store
    clear_stats();
    bus.MEM_R_EN   = 1'b1;
    bus.ALU_Res    = 32'd1036;
    bus.SRAM_RDATA = 32'hA5A50001;
    begin
      int sw;
      sw = 0;
      for (int i = 0; i < 40 && ready_cnt < 2; i++) begin
        tick();
        if (sw == 1) begin
          bus.MEM_R_EN = 1'b0;
          bus.MEM_W_EN = 1'b0;
          sw = 2;
        end
        if (ready_cnt == 1 && sw == 0) begin
          bus.MEM_R_EN = 1'b1;
          bus.MEM_W_EN = 1'b1;
          bus.ALU_Res  = 32'd1028;
          bus.Val_Rm   = 32'hCAFEF00D;
          sw = 1;
        end
      end
    end
    chk("t4_ready_cnt", ready_cnt,                   32'd2);
    chk("t4_gap",       ready_cyc[1] - ready_cyc[0], 32'd7);
    chk("t4_we",        seen_we,                     32'd1);
    chk("t4_addr",      seen_addr,                   32'd1);
    chk("t4_rdata",     bus.Read_Data,               32'hA5A50001);

    // Reset in ACCESS cycle 3
    clear_stats();
    bus.MEM_R_EN = 1'b1;
    bus.ALU_Res  = 32'd1040;
    tick();
    bus.MEM_R_EN = 1'b0;
    tick();
    tick();
    RST = 1'b1;
    #1;
    chk("t5_req_drop", bus.SRAM_REQ, 32'd0);
    tick();
    RST = 1'b0;
    repeat (8) tick();
    chk("t5_no_ready", ready_cnt, 32'd0);
    clear_stats();
    bus.MEM_R_EN = 1'b1;
    bus.ALU_Res  = 32'd1044;
    tick();
    bus.MEM_R_EN = 1'b0;
    wait_ready(1);
    chk("t5_req_len", req_cycles, 32'd5);
    chk("t5_freeze",  freeze_cnt, 32'd6);
    chk("t5_addr",    seen_addr,  32'd5);
`else
    // ACK-terminated access; an idle ACK pulse must be ignored
    bus.MEM_R_EN = 1'b0;
    RST = 1'b0;
    clear_stats();
    bus.SRAM_ACK = 1'b1;
    tick();
    bus.SRAM_ACK = 1'b0;
    chk("t6_idle_ack", req_cycles, 32'd0);
    bus.MEM_R_EN   = 1'b1;
    bus.ALU_Res    = 32'd1032;
    bus.SRAM_RDATA = 32'h600D600D;
    tick();
    bus.MEM_R_EN = 1'b0;
    repeat (8) tick();
    bus.SRAM_ACK = 1'b1;
    tick();
    bus.SRAM_ACK = 1'b0;
    chk("t6_not_yet", ready_cnt, 32'd0);
    tick();
    chk("t6_ready_cnt", ready_cnt,     32'd1);
    chk("t6_req_len",   req_cycles,    32'd9);
    chk("t6_rdata",     bus.Read_Data, 32'h600D600D);
`endif

    // Randomized traffic checked every cycle by the model
    for (int i = 0; i < 3000; i++) begin
      RST            = ($urandom_range(0, 149) == 0);
      bus.MEM_R_EN   = ($urandom_range(0, 2) == 0);
      bus.MEM_W_EN   = ($urandom_range(0, 2) == 0);
      bus.ALU_Res    = ($urandom_range(0, 3) == 0) ? 32'($urandom)
                                                   : BASE + 32'($urandom_range(0, 16383));
      bus.Val_Rm     = 32'($urandom);
      bus.SRAM_RDATA = 32'($urandom);
      bus.SRAM_ACK   = ($urandom_range(0, 3) == 0);
      tick();
    end
    RST          = 1'b0;
    bus.MEM_R_EN = 1'b0;
    bus.MEM_W_EN = 1'b0;
    bus.SRAM_ACK = 1'b1;
    repeat (W + 4) tick();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
